keypad_entry_ctrl: RTL and testbench

//  Converts raw keypad decoder output (4-bit key code plus key-held level) into clean entry

---
 rtl/kp_pkg.sv | 20 ++
 rtl/key_debounce.sv | 91 +++++++++
 rtl/keypad_entry_ctrl.sv | 119 +++++++++++
 tb/tb_keypad_entry_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared keypad definitions: special key codes and the debouncer state encoding.
package kp_pkg;

  localparam logic [3:0] KEY_SIGN  = 4'hA;
  localparam logic [3:0] KEY_CLR   = 4'hB;
  localparam logic [3:0] KEY_DONE  = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  typedef enum logic [1:0] {
    REL_STABLE = 2'd0,
    PRESS_WAIT = 2'd1,
    PRS_STABLE = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises the raw keypad level and code, then debounces them into a single
// key_evt pulse per physical press, with the accepted code on key_val.
module key_debounce
  import kp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_pressed,
  output logic       key_evt,
  output logic [3:0] key_val
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          pressed_meta;
  logic          pressed_sync;
  logic [3:0]    code_meta;
  logic [3:0]    code_sync;
  db_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pressed_meta <= 1'b0;
      pressed_sync <= 1'b0;
      code_meta    <= '0;
      code_sync    <= '0;
    end else begin
      pressed_meta <= key_pressed;
      pressed_sync <= pressed_meta;
      code_meta    <= key_code;
      code_sync    <= code_meta;
    end
  end

  // A press is accepted only after the level and code stay put for the full window;
  // release goes through its own window so bounce on release cannot re-trigger.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= REL_STABLE;
      cnt     <= '0;
      key_val <= '0;
    end else begin
      case (state)
        REL_STABLE: begin
          if (pressed_sync) begin
            state   <= PRESS_WAIT;
            key_val <= code_sync;
            cnt     <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed_sync) begin
            state <= REL_STABLE;
          end else if (code_sync != key_val) begin
            key_val <= code_sync;
            cnt     <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRS_STABLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRS_STABLE: begin
          if (!pressed_sync) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end
        end
        REL_WAIT: begin
          if (pressed_sync) begin
            state <= PRS_STABLE;
          end else if (cnt == CNT_LAST) begin
            state <= REL_STABLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= REL_STABLE;
      endcase
    end
  end

  assign key_evt = (state == PRESS_WAIT) && pressed_sync &&
                   (code_sync == key_val) && (cnt == CNT_LAST);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Turns debounced keypad events into signed entry values and one-cycle
// data_valid / input_done / reject strobes for the regression core.
module keypad_entry_ctrl
  import kp_pkg::*;
#(
  parameter int ELEM_WIDTH      = 12,
  parameter int MAX_DIGITS      = 3,
  parameter int DEBOUNCE_CYCLES = 4096,
  parameter int MAX_ENTRIES     = 12
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [3:0]                        key_code,
  input  logic                              key_pressed,
  input  logic                              ready,
  output logic [ELEM_WIDTH-1:0]             data_out,
  output logic                              data_valid,
  output logic                              input_done,
  output logic                              reject,
  output logic                              overflow,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
  output logic                              negative,
  output logic [3:0]                        entry_count
);

  localparam int AW  = ELEM_WIDTH - 1;
  localparam int PW  = ELEM_WIDTH + 3;
  localparam int DCW = $clog2(MAX_DIGITS + 1);
  localparam logic [PW-1:0]  ACC_MAX   = {4'b0000, {AW{1'b1}}};
  localparam logic [DCW-1:0] DIGIT_MAX = DCW'(MAX_DIGITS);
  localparam logic [3:0]     ENTRY_MAX = 4'(MAX_ENTRIES);

  logic                  key_evt;
  logic [3:0]            key_val;
  logic [AW-1:0]         acc;
  logic [PW-1:0]         acc_scaled;
  logic [ELEM_WIDTH-1:0] entry_val;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .key_code   (key_code),
    .key_pressed(key_pressed),
    .key_evt    (key_evt),
    .key_val    (key_val)
  );

  // The extra 4 bits hold acc*10+9 exactly, so saturation is a plain compare.
  assign acc_scaled = ({4'b0000, acc} * PW'(10)) + {{(PW-4){1'b0}}, key_val};
  assign entry_val  = negative ? (ELEM_WIDTH'(0) - {1'b0, acc}) : {1'b0, acc};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      input_done  <= 1'b0;
      reject      <= 1'b0;
      overflow    <= 1'b0;
      digit_count <= '0;
      negative    <= 1'b0;
      entry_count <= '0;
    end else begin
      data_valid <= 1'b0;
      input_done <= 1'b0;
      reject     <= 1'b0;
      if (key_evt) begin
        if (is_digit(key_val)) begin
          if (digit_count == DIGIT_MAX) begin
            reject <= 1'b1;
          end else begin
            digit_count <= digit_count + DCW'(1);
            if (acc_scaled > ACC_MAX) begin
              acc      <= {AW{1'b1}};
              overflow <= 1'b1;
            end else begin
              acc <= acc_scaled[AW-1:0];
            end
          end
        end else begin
          case (key_val)
            KEY_SIGN: negative <= ~negative;
            KEY_CLR: begin
              acc         <= '0;
              digit_count <= '0;
              negative    <= 1'b0;
              overflow    <= 1'b0;
            end
            KEY_ENTER: begin
              if (ready && (digit_count != '0)) begin
                data_out    <= entry_val;
                data_valid  <= 1'b1;
                entry_count <= (entry_count == ENTRY_MAX) ? entry_count : entry_count + 4'd1;
                acc         <= '0;
                digit_count <= '0;
                negative    <= 1'b0;
                overflow    <= 1'b0;
              end else begin
                reject <= 1'b1;
              end
            end
            KEY_DONE: begin
              input_done  <= 1'b1;
              entry_count <= '0;
              acc         <= '0;
              digit_count <= '0;
              negative    <= 1'b0;
              overflow    <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl; a second instance with MAX_DIGITS=4
// shares the same pins and is only examined for the saturation scenario.
module tb_keypad_entry_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key_code = 4'h0;
  logic        key_pressed = 1'b0;
  logic        ready = 1'b1;

  logic [11:0] data_out;
  logic        data_valid, input_done, reject, overflow, negative;
  logic [1:0]  digit_count;
  logic [3:0]  entry_count;

  logic [11:0] data_out4;
  logic        data_valid4, input_done4, reject4, overflow4, negative4;
  logic [2:0]  digit_count4;
  logic [3:0]  entry_count4;

  int tests_run = 0;
  int tests_failed = 0;
  int dv_cnt = 0;
  int rej_cnt = 0;
  int done_cnt = 0;
  logic [11:0] last_data = '0;

  always #5 clock = ~clock;

  keypad_entry_ctrl #(.ELEM_WIDTH(12), .MAX_DIGITS(3), .DEBOUNCE_CYCLES(4), .MAX_ENTRIES(12)) u_dut (
    .clock(clock), .reset(reset), .key_code(key_code), .key_pressed(key_pressed), .ready(ready),
    .data_out(data_out), .data_valid(data_valid), .input_done(input_done), .reject(reject),
    .overflow(overflow), .digit_count(digit_count), .negative(negative), .entry_count(entry_count)
  );

  keypad_entry_ctrl #(.ELEM_WIDTH(12), .MAX_DIGITS(4), .DEBOUNCE_CYCLES(4), .MAX_ENTRIES(12)) u_dut4 (
    .clock(clock), .reset(reset), .key_code(key_code), .key_pressed(key_pressed), .ready(ready),
    .data_out(data_out4), .data_valid(data_valid4), .input_done(input_done4), .reject(reject4),
    .overflow(overflow4), .digit_count(digit_count4), .negative(negative4), .entry_count(entry_count4)
  );

  always @(negedge clock) begin
    if (data_valid) begin
      dv_cnt = dv_cnt + 1;
      last_data = data_out;
    end
    if (reject) rej_cnt = rej_cnt + 1;
    if (input_done) done_cnt = done_cnt + 1;
  end

  task automatic press_key(input logic [3:0] code, input int hold = 10, input int rel = 10);
    @(posedge clock); #1;
    key_code = code;
    key_pressed = 1'b1;
    repeat (hold) @(posedge clock);
    #1 key_pressed = 1'b0;
    repeat (rel) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clock);
    tests_run++;
    if (data_out !== 12'd0 || data_valid !== 1'b0 || input_done !== 1'b0 || reject !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got data_out=%0h dv=%b done=%b rej=%b, expected all 0", data_out, data_valid, input_done, reject);
    end
    tests_run++;
    if (overflow !== 1'b0 || digit_count !== 2'd0 || negative !== 1'b0 || entry_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got ovf=%b dc=%0d neg=%b ec=%0d, expected all 0", overflow, digit_count, negative, entry_count);
    end
    @(posedge clock); #1 reset = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  task automatic test_digits_enter;
    int dv0;
    dv0 = dv_cnt;
    press_key(4'd1); press_key(4'd2); press_key(4'd3);
    tests_run++;
    if (digit_count !== 2'd3) begin
      tests_failed++;
      $display("[TB] FAIL digits_count: got %0d, expected 3", digit_count);
    end
    ready = 1'b1;
    press_key(4'hE);
    tests_run++;
    if (dv_cnt - dv0 != 1 || last_data !== 12'd123) begin
      tests_failed++;
      $display("[TB] FAIL enter_123: got %0d strobes data=%0d, expected 1 strobe data=123", dv_cnt - dv0, last_data);
    end
    tests_run++;
    if (entry_count !== 4'd1 || digit_count !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL enter_counts: got ec=%0d dc=%0d, expected ec=1 dc=0", entry_count, digit_count);
    end
  endtask

  task automatic test_negative;
    press_key(4'hA);
    tests_run++;
    if (negative !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sign_toggle: got %b, expected 1", negative);
    end
    press_key(4'd4); press_key(4'd5); press_key(4'hE);
    tests_run++;
    if (last_data !== 12'hFD3 || entry_count !== 4'd2 || negative !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL enter_neg45: got data=%h ec=%0d neg=%b, expected data=fd3 ec=2 neg=0", last_data, entry_count, negative);
    end
  endtask

  task automatic test_max_digits;
    int r0;
    r0 = rej_cnt;
    press_key(4'd9); press_key(4'd9); press_key(4'd9); press_key(4'd9);
    tests_run++;
    if (rej_cnt - r0 != 1 || digit_count !== 2'd3) begin
      tests_failed++;
      $display("[TB] FAIL max_digits: got rejects=%0d dc=%0d, expected rejects=1 dc=3", rej_cnt - r0, digit_count);
    end
    press_key(4'hB);
    tests_run++;
    if (digit_count !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL clear_digits: got %0d, expected 0", digit_count);
    end
  endtask

  task automatic test_chatter;
    int r0;
    r0 = rej_cnt;
    @(posedge clock); #1 key_code = 4'd3;
    for (int i = 0; i < 10; i++) begin
      key_pressed = ~key_pressed;
      repeat (2) @(posedge clock);
      #1;
    end
    key_pressed = 1'b1;
    repeat (10) @(posedge clock);
    #1 key_pressed = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    tests_run++;
    if (digit_count !== 2'd1 || rej_cnt != r0) begin
      tests_failed++;
      $display("[TB] FAIL chatter: got dc=%0d rejects=%0d, expected dc=1 rejects=0", digit_count, rej_cnt - r0);
    end
    press_key(4'hB);
  endtask

  task automatic test_not_ready;
    int r0, dv0;
    press_key(4'd7);
    r0 = rej_cnt; dv0 = dv_cnt;
    ready = 1'b0;
    press_key(4'hE);
    tests_run++;
    if (rej_cnt - r0 != 1 || dv_cnt != dv0 || digit_count !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL not_ready: got rejects=%0d dv=%0d dc=%0d, expected rejects=1 dv=0 dc=1", rej_cnt - r0, dv_cnt - dv0, digit_count);
    end
    ready = 1'b1;
    press_key(4'hE);
    tests_run++;
    if (dv_cnt - dv0 != 1 || last_data !== 12'd7 || entry_count !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL ready_enter7: got dv=%0d data=%0d ec=%0d, expected dv=1 data=7 ec=3", dv_cnt - dv0, last_data, entry_count);
    end
    press_key(4'hC);
    tests_run++;
    if (rej_cnt - r0 != 1 || digit_count !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL ignored_key: got rejects=%0d dc=%0d, expected rejects=1 dc=0", rej_cnt - r0, digit_count);
    end
  endtask

  task automatic test_overflow;
    press_key(4'hB);
    press_key(4'd5); press_key(4'd0); press_key(4'd0); press_key(4'd0);
    tests_run++;
    if (overflow4 !== 1'b1 || digit_count4 !== 3'd4) begin
      tests_failed++;
      $display("[TB] FAIL overflow_set: got ovf=%b dc=%0d, expected ovf=1 dc=4", overflow4, digit_count4);
    end
    press_key(4'hE);
    tests_run++;
    if (data_out4 !== 12'd2047 || overflow4 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL overflow_enter: got data=%0d ovf=%b, expected data=2047 ovf=0", data_out4, overflow4);
    end
    press_key(4'd5); press_key(4'd0); press_key(4'd0); press_key(4'd0);
    press_key(4'hB);
    tests_run++;
    if (overflow4 !== 1'b0 || digit_count4 !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL overflow_clear: got ovf=%b dc=%0d, expected ovf=0 dc=0", overflow4, digit_count4);
    end
  endtask

  task automatic test_latency;
    int lat;
    lat = 0;
    @(posedge clock); #1;
    key_code = 4'hE;
    key_pressed = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (reject && lat == 0) lat = k;
    end
    #1 key_pressed = 1'b0;
    repeat (10) @(posedge clock);
    tests_run++;
    if (lat != 7) begin
      tests_failed++;
      $display("[TB] FAIL latency: got %0d cycles, expected 7", lat);
    end
  endtask

  task automatic test_entry_saturate;
    int dv0;
    dv0 = dv_cnt;
    for (int i = 0; i < 13; i++) begin
      press_key(4'd1);
      press_key(4'hE);
    end
    tests_run++;
    if (entry_count !== 4'd12 || dv_cnt - dv0 != 13) begin
      tests_failed++;
      $display("[TB] FAIL entry_saturate: got ec=%0d dv=%0d, expected ec=12 dv=13", entry_count, dv_cnt - dv0);
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    press_key(4'hA);
    press_key(4'd2);
    @(posedge clock); #1;
    key_code = 4'd5;
    key_pressed = 1'b1;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (data_out !== 12'd0 || entry_count !== 4'd0 || digit_count !== 2'd0 || negative !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got data=%0d ec=%0d dc=%0d neg=%b ovf=%b, expected all 0", data_out, entry_count, digit_count, negative, overflow);
    end
    key_pressed = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    tests_run++;
    if (digit_count !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_drop: got dc=%0d, expected 0", digit_count);
    end
    press_key(4'd3);
    press_key(4'hE);
    d0 = done_cnt;
    press_key(4'hD);
    tests_run++;
    if (done_cnt - d0 != 1 || entry_count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL done: got pulses=%0d ec=%0d, expected pulses=1 ec=0", done_cnt - d0, entry_count);
    end
  endtask

  initial begin
    test_reset();
    test_digits_enter();
    test_negative();
    test_max_digits();
    test_chatter();
    test_not_ready();
    test_overflow();
    test_latency();
    test_entry_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
